// File: rtl/i2c_expander_pkg.sv
// Shared definitions for the I2C I/O-expander target: register indices,
// register reset values and the protocol FSM state encoding.
package i2c_expander_pkg;

    // Register map (pointer values)
    localparam logic [2:0] REG_IN0  = 3'd0;
    localparam logic [2:0] REG_IN1  = 3'd1;
    localparam logic [2:0] REG_OUT0 = 3'd2;
    localparam logic [2:0] REG_OUT1 = 3'd3;
    localparam logic [2:0] REG_INV0 = 3'd4;
    localparam logic [2:0] REG_INV1 = 3'd5;
    localparam logic [2:0] REG_CFG0 = 3'd6;
    localparam logic [2:0] REG_CFG1 = 3'd7;

    // Register reset values
    localparam logic [7:0] OUT_RST = 8'hFF;
    localparam logic [7:0] INV_RST = 8'h00;
    localparam logic [7:0] CFG_RST = 8'hFF;

    // Protocol FSM states
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one raw I2C pad input: 2-FF synchronizer followed by a
// stability filter. The filtered level only follows the synchronized line
// after it has held a new value for FILTER_LEN consecutive cycles. Rise and
// fall pulses compare the filtered level with its registered previous value.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

    logic       sync1_q, sync2_q;
    logic       level_q, level_d;
    logic       prev_q;
    logic [3:0] cnt_q, cnt_d;

    // Synchronizer, filter state and previous-level register (idle bus is high)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= 4'd0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    // Count cycles the synchronized line differs from the filtered level;
    // any return to the current level restarts the count
    always_comb begin
        level_d = level_q;
        cnt_d   = 4'd0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;
    assign fall_o  = ~level_q & prev_q;

endmodule

// File: rtl/i2c_expander_target.sv
// PCA9555-style 16-bit I/O expander exposed as an I2C target at a fixed
// 7-bit address. Open-drain SDA only, no clock stretching. Supports pointer
// write, paired data writes and pointer-then-read with pair auto-increment.
// Handshake: none; I2C framing is the only interface. wr_strobe is a
// one-cycle pulse and wr_index is valid in that same cycle.
module i2c_expander_target
    import i2c_expander_pkg::*;
#(
    parameter logic [6:0]  ADDRESS    = 7'h24,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       clk48,
    input  logic       reset_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] port0_in,
    input  logic [7:0] port1_in,
    output logic [7:0] port0_out,
    output logic [7:0] port1_out,
    output logic [7:0] port0_cfg,
    output logic [7:0] port1_cfg,
    output logic       busy,
    output logic       wr_strobe,
    output logic [2:0] wr_index,
    output state_e     dbg_state_o
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk_i (clk48), .rst_ni (reset_n), .line_i (scl_i),
        .level_o (scl), .rise_o (scl_rise), .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk_i (clk48), .rst_ni (reset_n), .line_i (sda_i),
        .level_o (sda), .rise_o (sda_rise), .fall_o (sda_fall)
    );

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] ptr_q, ptr_d;
    logic       half_q, half_d;      // ACK-phase: SCL rise of the ACK clock seen
    logic [7:0] out0_q, out0_d, out1_q, out1_d;
    logic [7:0] inv0_q, inv0_d, inv1_q, inv1_d;
    logic [7:0] cfg0_q, cfg0_d, cfg1_q, cfg1_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [2:0] wr_index_q, wr_index_d;

    logic       start_det, stop_det, byte_done;
    logic [7:0] rx_byte;
    logic [2:0] ptr_pair;
    logic [7:0] reg_file [8];

    assign start_det = sda_fall & scl;
    assign stop_det  = sda_rise & scl;
    assign rx_byte   = {shift_q[6:0], sda};
    assign byte_done = scl_rise && (bit_cnt_q == 3'd7);
    assign ptr_pair  = {ptr_q[2:1], ~ptr_q[0]};

    // Readable view of the register map; inputs are inverted live pins
    assign reg_file[REG_IN0]  = port0_in ^ inv0_q;
    assign reg_file[REG_IN1]  = port1_in ^ inv1_q;
    assign reg_file[REG_OUT0] = out0_q;
    assign reg_file[REG_OUT1] = out1_q;
    assign reg_file[REG_INV0] = inv0_q;
    assign reg_file[REG_INV1] = inv1_q;
    assign reg_file[REG_CFG0] = cfg0_q;
    assign reg_file[REG_CFG1] = cfg1_q;

    // State and register file update
    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            ptr_q       <= 3'd0;
            half_q      <= 1'b0;
            out0_q      <= OUT_RST;
            out1_q      <= OUT_RST;
            inv0_q      <= INV_RST;
            inv1_q      <= INV_RST;
            cfg0_q      <= CFG_RST;
            cfg1_q      <= CFG_RST;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            half_q      <= half_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            inv0_q      <= inv0_d;
            inv1_q      <= inv1_d;
            cfg0_q      <= cfg0_d;
            cfg1_q      <= cfg1_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
        end
    end

    // Protocol FSM: START/STOP override everything; bits shift in on SCL
    // rise; SDA drive changes only on the cycle after an SCL fall
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        half_d      = half_q;
        out0_d      = out0_q;
        out1_d      = out1_q;
        inv0_d      = inv0_q;
        inv1_d      = inv1_q;
        cfg0_d      = cfg0_q;
        cfg1_d      = cfg1_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            half_d    = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            half_d    = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (byte_done) begin
                        half_d = 1'b0;
                        if (state_q == ST_ADDR) begin
                            if (rx_byte[7:1] == ADDRESS) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else if (state_q == ST_PTR) begin
                            ptr_d   = rx_byte[2:0];
                            state_d = ST_PTR_ACK;
                        end else begin
                            unique case (ptr_q)
                                REG_OUT0: out0_d = rx_byte;
                                REG_OUT1: out1_d = rx_byte;
                                REG_INV0: inv0_d = rx_byte;
                                REG_INV1: inv1_d = rx_byte;
                                REG_CFG0: cfg0_d = rx_byte;
                                REG_CFG1: cfg1_d = rx_byte;
                                default:  ;  // input registers are read-only
                            endcase
                            wr_strobe_d = 1'b1;
                            wr_index_d  = ptr_q;
                            ptr_d       = ptr_pair;
                            state_d     = ST_WDATA_ACK;
                        end
                    end
                end

                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_rise) begin
                        half_d = 1'b1;
                    end
                    if (scl_fall) begin
                        if (!half_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            half_d    = 1'b0;
                            bit_cnt_d = 3'd0;
                            sda_oe_d  = 1'b0;
                            if (state_q == ST_ADDR_ACK && shift_q[0]) begin
                                shift_d  = reg_file[ptr_q];
                                sda_oe_d = ~reg_file[ptr_q][7];
                                state_d  = ST_RDATA;
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_PTR;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end

                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            half_d  = 1'b0;
                            state_d = ST_RDATA_ACK;
                        end
                    end
                    if (scl_fall) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end

                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda) begin
                            state_d = ST_IGNORE;
                        end else begin
                            half_d = 1'b1;
                        end
                    end
                    if (scl_fall) begin
                        if (!half_q) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            half_d    = 1'b0;
                            bit_cnt_d = 3'd0;
                            ptr_d     = ptr_pair;
                            shift_d   = reg_file[ptr_pair];
                            sda_oe_d  = ~reg_file[ptr_pair][7];
                            state_d   = ST_RDATA;
                        end
                    end
                end

                default: ;  // IDLE / IGNORE wait for START
            endcase
        end
    end

    assign sda_oe      = sda_oe_q;
    assign busy        = busy_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_index    = wr_index_q;
    assign port0_out   = out0_q;
    assign port1_out   = out1_q;
    assign port0_cfg   = cfg0_q;
    assign port1_cfg   = cfg1_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_expander_target.sv
// Bench for i2c_expander_target: bench-side I2C master, passive bus monitor
// that decodes 9-bit frames, write-strobe monitor, and a register-level
// reference model of the expander.
module tb_i2c_expander_target;
    import i2c_expander_pkg::*;

    localparam int Q = 20;  // quarter SCL period in clk48 cycles

    // ---------------- clock / reset ----------------
    logic clk48 = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk48 = ~clk48;

    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, busy, wr_strobe;
    logic [7:0] port0_in = 8'h00, port1_in = 8'h00;
    logic [7:0] port0_out, port1_out, port0_cfg, port1_cfg;
    logic [2:0] wr_index;
    state_e     dbg_state;

    assign sda_line = sda_m & ~sda_oe;

    i2c_expander_target #(.ADDRESS(7'h24), .FILTER_LEN(4)) dut (
        .clk48(clk48), .reset_n(reset_n), .scl_i(scl_m), .sda_i(sda_line),
        .sda_oe(sda_oe), .port0_in(port0_in), .port1_in(port1_in),
        .port0_out(port0_out), .port1_out(port1_out),
        .port0_cfg(port0_cfg), .port1_cfg(port1_cfg),
        .busy(busy), .wr_strobe(wr_strobe), .wr_index(wr_index),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [8:0]  exp_frame_q[$];  // {byte, ack bit seen on the bus}
    logic [10:0] exp_wr_q[$];     // {register index, data}

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_reg [8];
    logic [2:0] m_ptr;

    task automatic model_reset();
        m_reg[2] = 8'hFF; m_reg[3] = 8'hFF;
        m_reg[4] = 8'h00; m_reg[5] = 8'h00;
        m_reg[6] = 8'hFF; m_reg[7] = 8'hFF;
        m_reg[0] = 8'h00; m_reg[1] = 8'h00;
        m_ptr = 3'd0;
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] idx);
        if (idx == 3'd0) return port0_in ^ m_reg[4];
        if (idx == 3'd1) return port1_in ^ m_reg[5];
        return m_reg[idx];
    endfunction

    // Pairs are (2,3), (4,5), (6,7), (0,1): the partner differs in bit 0
    function automatic logic [2:0] pair_of(input logic [2:0] idx);
        return (idx % 2 == 0) ? idx + 3'd1 : idx - 3'd1;
    endfunction

    task automatic model_write(input logic [7:0] data);
        if (m_ptr >= 3'd2) m_reg[m_ptr] = data;
        exp_wr_q.push_back({m_ptr, data});
        m_ptr = pair_of(m_ptr);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_port0_out"}, 16'(port0_out), 16'(m_reg[2]));
        check({tag, "_port1_out"}, 16'(port1_out), 16'(m_reg[3]));
        check({tag, "_port0_cfg"}, 16'(port0_cfg), 16'(m_reg[6]));
        check({tag, "_port1_cfg"}, 16'(port1_cfg), 16'(m_reg[7]));
    endtask

    // ---------------- bus frame monitor ----------------
    logic       mon_scl_q = 1'b1, mon_sda_q = 1'b1;
    int         mon_cnt = 0;
    logic [8:0] mon_frame = 9'h0;

    always @(negedge clk48) begin
        if (!reset_n) begin
            mon_cnt = 0;
        end else if (scl_m && mon_scl_q && (sda_line !== mon_sda_q)) begin
            mon_cnt = 0;  // START or STOP discards any partial frame
        end else if (scl_m && !mon_scl_q) begin
            mon_frame = {mon_frame[7:0], sda_line};
            mon_cnt++;
            if (mon_cnt == 9) begin
                mon_cnt = 0;
                if (exp_frame_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bus_frame_unexpected actual=0x%0h required=none", mon_frame);
                end else begin
                    check("bus_frame", 16'(mon_frame), 16'(exp_frame_q.pop_front()));
                end
            end
        end
        mon_scl_q = scl_m;
        mon_sda_q = sda_line;
    end

    // ---------------- write strobe monitor ----------------
    logic [10:0] wr_exp;
    always @(negedge clk48) begin
        if (reset_n && wr_strobe) begin
            if (exp_wr_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL wr_strobe_unexpected actual=%0d required=none", wr_index);
            end else begin
                wr_exp = exp_wr_q.pop_front();
                check("wr_index", 16'(wr_index), 16'(wr_exp[10:8]));
                case (wr_exp[10:8])
                    3'd2: check("wr_port0_out", 16'(port0_out), 16'(wr_exp[7:0]));
                    3'd3: check("wr_port1_out", 16'(port1_out), 16'(wr_exp[7:0]));
                    3'd6: check("wr_port0_cfg", 16'(port0_cfg), 16'(wr_exp[7:0]));
                    3'd7: check("wr_port1_cfg", 16'(port1_cfg), 16'(wr_exp[7:0]));
                    default: ;
                endcase
            end
        end
    end

    // ---------------- master driver tasks ----------------
    task automatic tick_q();
        repeat (Q) @(negedge clk48);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick_q();
        scl_m = 1'b1; tick_q();
        sda_m = 1'b0; tick_q();
        scl_m = 1'b0; tick_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick_q();
        scl_m = 1'b1; tick_q();
        sda_m = 1'b1; tick_q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    tick_q();
        scl_m = 1'b1; tick_q(); tick_q();
        scl_m = 1'b0; tick_q();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack);
        exp_frame_q.push_back({b, exp_ack});
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(1'b1);
    endtask

    task automatic recv_byte(input logic [7:0] exp_b, input logic nack);
        exp_frame_q.push_back({exp_b, nack});
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        send_bit(nack);
    endtask

    // Write transaction: first data byte is the pointer, the rest are data
    task automatic wr_txn(input logic [6:0] addr, input int n, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] b2, input bit do_stop);
        logic [7:0] bytes [3];
        bit hit;
        hit = (addr == 7'h24);
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        bus_start();
        send_byte({addr, 1'b0}, !hit);
        check("busy_after_addr", 16'(busy), 16'(hit));
        if (hit) begin
            for (int i = 0; i < n; i++) begin
                if (i == 0) m_ptr = bytes[0][2:0];
                else model_write(bytes[i]);
                send_byte(bytes[i], 1'b0);
            end
        end
        if (do_stop || !hit) begin
            bus_stop();
            check("busy_after_stop", 16'(busy), 16'h0);
        end
    endtask

    // Read transaction from the current pointer; last byte is NACKed
    task automatic rd_txn(input int n);
        bus_start();
        send_byte({7'h24, 1'b1}, 1'b0);
        check("busy_in_read", 16'(busy), 16'h1);
        for (int i = 0; i < n; i++) begin
            recv_byte(model_read(m_ptr), (i == n - 1));
            if (i != n - 1) m_ptr = pair_of(m_ptr);
        end
        check("sda_released_after_nack", 16'(sda_oe), 16'h0);
        bus_stop();
        check("busy_after_read_stop", 16'(busy), 16'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        repeat (95000) @(posedge clk48);
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        logic [6:0] raddr;
        int kind, n;
        model_reset();
        repeat (5) @(negedge clk48);
        check("rst_sda_oe", 16'(sda_oe), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_wr_strobe", 16'(wr_strobe), 16'h0);
        check("rst_state", 16'(dbg_state), 16'(ST_IDLE));
        check_regs("rst");
        reset_n = 1'b1;
        repeat (5) @(negedge clk48);

        // Pair write to outputs
        wr_txn(7'h24, 3, 8'h02, 8'h55, 8'hAA, 1'b1);
        check_regs("t1");

        // Inversion write, then pointer-then-read of the inputs
        port0_in = 8'h33; port1_in = 8'h3C;
        wr_txn(7'h24, 3, 8'h04, 8'h0F, 8'hF0, 1'b1);
        wr_txn(7'h24, 1, 8'h00, 8'h00, 8'h00, 1'b0);
        rd_txn(2);

        // Foreign address: no ACK, nothing changes
        wr_txn(7'h25, 3, 8'h02, 8'h11, 8'h22, 1'b1);
        check_regs("t3");

        // Config write, then read starting at pointer 7
        wr_txn(7'h24, 3, 8'h06, 8'h00, 8'hC0, 1'b1);
        wr_txn(7'h24, 1, 8'h07, 8'h00, 8'h00, 1'b0);
        rd_txn(2);
        check_regs("t4");

        // START after 4 data bits of a write to reg 2
        bus_start();
        send_byte(8'h48, 1'b0);
        send_byte(8'h02, 1'b0);
        m_ptr = 3'd2;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        bus_start();
        send_byte(8'h48, 1'b0);
        bus_stop();
        check_regs("t5");

        // Async reset while the target drives a 0 read bit
        wr_txn(7'h24, 3, 8'h02, 8'h12, 8'h34, 1'b1);
        bus_start();
        send_byte(8'h49, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk48);
            if (dbg_state == ST_RDATA && sda_oe) found = 1'b1;
        end
        check("reset_wait_read_drive", 16'(found), 16'h1);
        reset_n = 1'b0;
        #1;
        check("async_reset_sda_oe", 16'(sda_oe), 16'h0);
        repeat (3) @(negedge clk48);
        reset_n = 1'b1;
        model_reset();
        check_regs("t6");
        check("t6_busy", 16'(busy), 16'h0);
        check("t6_state", 16'(dbg_state), 16'(ST_IDLE));
        bus_stop();
        port0_in = 8'hA7; port1_in = 8'h5E;
        rd_txn(2);  // pointer restarts at 0

        // Randomized transactions
        for (int t = 0; t < 8; t++) begin
            port0_in = 8'($urandom);
            port1_in = 8'($urandom);
            kind = $urandom_range(0, 3);
            n = $urandom_range(1, 3);
            case (kind)
                0: wr_txn(7'h24, n, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
                1: begin
                    wr_txn(7'h24, 1, 8'($urandom), 8'h00, 8'h00, 1'b0);
                    rd_txn(n);
                end
                2: rd_txn($urandom_range(1, 2));
                default: begin
                    raddr = 7'($urandom_range(0, 127));
                    if (raddr == 7'h24) raddr = 7'h26;
                    wr_txn(raddr, 2, 8'h02, 8'($urandom), 8'h00, 1'b1);
                end
            endcase
        end

        repeat (20) @(negedge clk48);
        check_regs("final");
        check("frames_pending", 16'(exp_frame_q.size()), 16'h0);
        check("writes_pending", 16'(exp_wr_q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
